// File: rtl/spi_ram_if.sv
// Command/response bus between an SPI slave front end and the spi_ram store.
// The SPI side drives command frames in; the RAM side returns read data and a
// sequencing error pulse.
interface spi_ram_if #(
  parameter int MEM_DEPTH = 256
);
  localparam int ADDR_SIZE = $clog2(MEM_DEPTH);

  logic [ADDR_SIZE+1:0] rx_data;
  logic                 rx_valid;
  logic [ADDR_SIZE-1:0] tx_data;
  logic                 tx_valid;
  logic                 seq_err;

  modport master (
    output rx_data,
    output rx_valid,
    input  tx_data,
    input  tx_valid,
    input  seq_err
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output tx_data,
    output tx_valid,
    output seq_err
  );
endinterface

// File: rtl/spi_ram.sv
// Word-addressed RAM driven by SPI command frames. A frame carries a 2-bit
// opcode and an address-wide payload: set write address, write data, set read
// address, read data. Data commands auto-increment their pointer and wrap at
// MEM_DEPTH-1. Data commands issued before any address command of the same
// direction are rejected with a one-cycle seq_err pulse.
module spi_ram #(
  parameter int MEM_DEPTH = 256
) (
  input  logic     clk,
  input  logic     rst_n,
  spi_ram_if.slave bus
);
  localparam int ADDR_SIZE = $clog2(MEM_DEPTH);

  localparam logic [ADDR_SIZE:0]   DEPTH_EXT = (ADDR_SIZE+1)'(MEM_DEPTH);
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  // Map a raw payload onto a legal address. The payload is narrower than
  // 2*MEM_DEPTH, so one conditional subtraction is a full modulo.
  function automatic logic [ADDR_SIZE-1:0] fold_addr(input logic [ADDR_SIZE-1:0] a);
    if ({1'b0, a} >= DEPTH_EXT) begin
      fold_addr = a - DEPTH_EXT[ADDR_SIZE-1:0];
    end else begin
      fold_addr = a;
    end
  endfunction

  // Pointer increment that wraps at the last implemented word.
  function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
    if (a == LAST_ADDR) begin
      next_addr = '0;
    end else begin
      next_addr = a + 1'b1;
    end
  endfunction

  logic [ADDR_SIZE-1:0] mem_q [0:MEM_DEPTH-1];

  logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic                 wa_ok_q, wa_ok_d;
  logic                 ra_ok_q, ra_ok_d;
  logic [ADDR_SIZE-1:0] tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 seq_err_q, seq_err_d;

  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_waddr;
  logic [ADDR_SIZE-1:0] mem_wdata;

  logic [1:0]           opcode;
  logic [ADDR_SIZE-1:0] payload;

  assign opcode  = bus.rx_data[ADDR_SIZE+1:ADDR_SIZE];
  assign payload = bus.rx_data[ADDR_SIZE-1:0];

  // Decode one command per valid cycle; pulses default low so they last one cycle.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    wa_ok_d    = wa_ok_q;
    ra_ok_d    = ra_ok_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    seq_err_d  = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = wr_ptr_q;
    mem_wdata  = payload;
    if (bus.rx_valid) begin
      case (opcode)
        OP_WR_ADDR: begin
          wr_ptr_d = fold_addr(payload);
          wa_ok_d  = 1'b1;
        end
        OP_WR_DATA: begin
          if (wa_ok_q) begin
            mem_we   = 1'b1;
            wr_ptr_d = next_addr(wr_ptr_q);
          end else begin
            seq_err_d = 1'b1;
          end
        end
        OP_RD_ADDR: begin
          rd_ptr_d = fold_addr(payload);
          ra_ok_d  = 1'b1;
        end
        OP_RD_DATA: begin
          if (ra_ok_q) begin
            tx_data_d  = mem_q[rd_ptr_q];
            tx_valid_d = 1'b1;
            rd_ptr_d   = next_addr(rd_ptr_q);
          end else begin
            seq_err_d = 1'b1;
          end
        end
        default: begin
          seq_err_d = 1'b0;
        end
      endcase
    end
  end

  // Control and output registers; cleared asynchronously so a new session
  // must re-issue address commands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wa_ok_q    <= 1'b0;
      ra_ok_q    <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wa_ok_q    <= wa_ok_d;
      ra_ok_q    <= ra_ok_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      seq_err_q  <= seq_err_d;
    end
  end

  // Storage array, deliberately not reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.seq_err  = seq_err_q;

endmodule

// File: tb/tb_spi_ram.sv
// Directed bench for spi_ram with MEM_DEPTH=256 (8-bit words, 10-bit frames).
// Inputs change on the falling edge; outputs are sampled on the falling edge
// after the rising edge that consumed a command.
module tb_spi_ram;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  spi_ram_if #(.MEM_DEPTH(256)) bus ();

  spi_ram #(.MEM_DEPTH(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one command for one rising edge, return at the following falling edge.
  task automatic cmd(input logic [9:0] v);
    bus.rx_valid = 1'b1;
    bus.rx_data  = v;
    @(negedge clk);
  endtask

  task automatic idle();
    bus.rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    #1;
    checks++;
    if (bus.tx_valid !== 1'b0) begin
      errors++; $display("FAIL reset_tx_valid got %b want 0", bus.tx_valid);
    end
    checks++;
    if (bus.tx_data !== 8'h00) begin
      errors++; $display("FAIL reset_tx_data got %h want 00", bus.tx_data);
    end
    checks++;
    if (bus.seq_err !== 1'b0) begin
      errors++; $display("FAIL reset_seq_err got %b want 0", bus.seq_err);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    cmd(10'h010);
    cmd(10'h1A5);
    cmd(10'h210);
    checks++;
    if (bus.tx_valid !== 1'b0) begin
      errors++; $display("FAIL wr_rd_early_valid got %b want 0", bus.tx_valid);
    end
    cmd(10'h300);
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA5) begin
      errors++; $display("FAIL wr_rd_pulse got v=%b d=%h want v=1 d=a5", bus.tx_valid, bus.tx_data);
    end
    checks++;
    if (bus.seq_err !== 1'b0) begin
      errors++; $display("FAIL wr_rd_seq_err got %b want 0", bus.seq_err);
    end
    idle();
    checks++;
    if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'hA5) begin
      errors++; $display("FAIL wr_rd_hold got v=%b d=%h want v=0 d=a5", bus.tx_valid, bus.tx_data);
    end
  endtask

  task automatic test_wrap();
    cmd(10'h0FF);
    cmd(10'h111);
    cmd(10'h122);
    cmd(10'h2FF);
    cmd(10'h300);
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h11) begin
      errors++; $display("FAIL wrap_first got v=%b d=%h want v=1 d=11", bus.tx_valid, bus.tx_data);
    end
    cmd(10'h300);
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h22 || bus.seq_err !== 1'b0) begin
      errors++; $display("FAIL wrap_second got v=%b d=%h e=%b want v=1 d=22 e=0",
                         bus.tx_valid, bus.tx_data, bus.seq_err);
    end
    idle();
    checks++;
    if (bus.tx_valid !== 1'b0) begin
      errors++; $display("FAIL wrap_pulse_end got %b want 0", bus.tx_valid);
    end
  endtask

  task automatic test_back_to_back();
    cmd(10'h030);
    cmd(10'h101);
    cmd(10'h102);
    cmd(10'h103);
    cmd(10'h230);
    for (int i = 1; i <= 3; i++) begin
      cmd(10'h300);
      checks++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'(i)) begin
        errors++; $display("FAIL b2b_read%0d got v=%b d=%h want v=1 d=%h",
                           i, bus.tx_valid, bus.tx_data, 8'(i));
      end
    end
    idle();
  endtask

  task automatic test_seq_err();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cmd(10'h300);
    checks++;
    if (bus.seq_err !== 1'b1 || bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00) begin
      errors++; $display("FAIL seq_rd got e=%b v=%b d=%h want e=1 v=0 d=00",
                         bus.seq_err, bus.tx_valid, bus.tx_data);
    end
    cmd(10'h155);
    checks++;
    if (bus.seq_err !== 1'b1) begin
      errors++; $display("FAIL seq_wr got %b want 1", bus.seq_err);
    end
    idle();
    checks++;
    if (bus.seq_err !== 1'b0) begin
      errors++; $display("FAIL seq_pulse_end got %b want 0", bus.seq_err);
    end
    cmd(10'h200);
    cmd(10'h300);
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h22) begin
      errors++; $display("FAIL seq_mem_intact got v=%b d=%h want v=1 d=22", bus.tx_valid, bus.tx_data);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    cmd(10'h020);
    cmd(10'h1C3);
    cmd(10'h020);
    cmd(10'h210);
    cmd(10'h300);
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA5) begin
      errors++; $display("FAIL mid_pre got v=%b d=%h want v=1 d=a5", bus.tx_valid, bus.tx_data);
    end
    bus.rx_data = 10'h300;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00 || bus.seq_err !== 1'b0) begin
      errors++; $display("FAIL mid_async got v=%b d=%h e=%b want all 0",
                         bus.tx_valid, bus.tx_data, bus.seq_err);
    end
    @(negedge clk);
    cmd(10'h177);
    cmd(10'h300);
    checks++;
    if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00 || bus.seq_err !== 1'b0) begin
      errors++; $display("FAIL mid_ignored got v=%b d=%h e=%b want all 0",
                         bus.tx_valid, bus.tx_data, bus.seq_err);
    end
    bus.rx_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    cmd(10'h177);
    checks++;
    if (bus.seq_err !== 1'b1) begin
      errors++; $display("FAIL mid_fresh_addr got %b want 1", bus.seq_err);
    end
    cmd(10'h220);
    cmd(10'h300);
    checks++;
    if (bus.tx_data !== 8'hC3) begin
      errors++; $display("FAIL mid_addr20 got %h want c3", bus.tx_data);
    end
    cmd(10'h200);
    cmd(10'h300);
    checks++;
    if (bus.tx_data !== 8'h22) begin
      errors++; $display("FAIL mid_addr00 got %h want 22", bus.tx_data);
    end
    idle();
  endtask

  task automatic test_idle();
    cmd(10'h001);
    cmd(10'h1E7);
    cmd(10'h201);
    idle();
    for (int i = 0; i < 20; i++) begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 10'($urandom);
      @(negedge clk);
      checks++;
      if (bus.tx_valid !== 1'b0 || bus.seq_err !== 1'b0) begin
        errors++; $display("FAIL idle_cycle%0d got v=%b e=%b want 0 0", i, bus.tx_valid, bus.seq_err);
      end
    end
    checks++;
    if (bus.tx_data !== 8'h22) begin
      errors++; $display("FAIL idle_hold got %h want 22", bus.tx_data);
    end
    cmd(10'h300);
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hE7) begin
      errors++; $display("FAIL idle_rd_ptr got v=%b d=%h want v=1 d=e7", bus.tx_valid, bus.tx_data);
    end
    cmd(10'h15A);
    cmd(10'h300);
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h5A) begin
      errors++; $display("FAIL idle_wr_ptr got v=%b d=%h want v=1 d=5a", bus.tx_valid, bus.tx_data);
    end
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_read();
    test_wrap();
    test_back_to_back();
    test_seq_err();
    test_reset_mid();
    test_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_ram.md
SPI_RAM -- requirements
Module: spi_ram

Interface
REQ-001 SHALL have parameter: MEM_DEPTH, default 256, number of memory words; ADDR_SIZE = clog2(MEM_DEPTH) is derived locally.
REQ-002 SHALL have port: clk  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: rx_data  input  ADDR_SIZE+2  command frame from SPI slave; [ADDR_SIZE+1:ADDR_SIZE] opcode, [ADDR_SIZE-1:0] payload.
REQ-005 SHALL have port: rx_valid  input  1  rx_data qualifier, sampled each cycle.
REQ-006 SHALL have port: tx_data  output  ADDR_SIZE  read data to SPI slave.
REQ-007 SHALL have port: tx_valid  output  1  tx_data qualifier, single-cycle pulse.
REQ-008 SHALL have port: seq_err  output  1  single-cycle pulse flagging an out-of-order command.

Function
REQ-009 SHALL hold MEM_DEPTH words of ADDR_SIZE bits; memory contents not reset.
REQ-010 SHALL act only in cycles with rx_valid=1; rx_valid=0 -> no state, memory or output change except pulse deassertion.
REQ-011 SHALL on opcode 00 (write address) load wr_ptr <= payload and set wa_ok=1.
REQ-012 SHALL on opcode 01 (write data) with wa_ok=1 write mem[wr_ptr] <= payload, then wr_ptr <= wr_ptr+1 modulo MEM_DEPTH.
REQ-013 SHALL on opcode 01 with wa_ok=0 perform no write, leave wr_ptr unchanged, assert seq_err next cycle.
REQ-014 SHALL on opcode 10 (read address) load rd_ptr <= payload and set ra_ok=1.
REQ-015 SHALL on opcode 11 (read data) with ra_ok=1 register tx_data <= mem[rd_ptr], assert tx_valid for exactly the next cycle, then rd_ptr <= rd_ptr+1 modulo MEM_DEPTH.
REQ-016 SHALL on opcode 11 with ra_ok=0 keep tx_valid=0, hold tx_data, assert seq_err next cycle.
REQ-017 SHALL have latency: command accepted at edge N -> tx_valid/seq_err high in cycle N+1, low in N+2 unless another qualifying command arrives.
REQ-018 SHALL hold tx_data stable between read-data commands.
REQ-019 SHALL return the newly written value when a read-data command follows a write-data command to the same address in a later cycle.
REQ-020 SHALL wrap pointers MEM_DEPTH-1 -> 0 silently, with no error flagged.
REQ-021 SHALL, when MEM_DEPTH is not a power of two, wrap at MEM_DEPTH-1 -> 0 and treat payload >= MEM_DEPTH as address modulo MEM_DEPTH.
REQ-022 SHALL keep wa_ok/ra_ok set once set, until reset.
REQ-023 SHALL accept back-to-back commands every cycle, including consecutive read-data commands giving consecutive tx_valid pulses.

Reset
REQ-024 SHALL on rst_n=0 immediately force tx_data=0, tx_valid=0, seq_err=0, wr_ptr=0, rd_ptr=0, wa_ok=0, ra_ok=0.
REQ-025 SHALL ignore rx_valid while rst_n=0; after reset deassertion, data commands need a fresh address command.

Verification (MEM_DEPTH=256: ADDR_SIZE=8, rx_data 10 bits)
REQ-026 SHALL cover: reset asserted mid-traffic -> all outputs 0 within the same cycle; rx_valid pulses ignored while rst_n=0.
REQ-027 SHALL cover: rx_data 0x010, 0x1A5, 0x210, 0x300 on consecutive cycles -> tx_valid single pulse one cycle after 0x300, tx_data=0xA5.
REQ-028 SHALL cover: 0x0FF, 0x111, 0x122, then 0x2FF, 0x300, 0x300 -> tx_data 0x11 then 0x22 on back-to-back tx_valid pulses (wrap to address 0).
REQ-029 SHALL cover: after reset, 0x300 -> seq_err pulse, tx_valid stays 0, tx_data stays 0; then 0x155 -> seq_err pulse, memory unchanged.
REQ-030 SHALL cover: 0x020, reset pulse, then 0x177 -> seq_err pulse, no write to address 0x20 or 0x00.
REQ-031 SHALL cover: rx_valid=0 with rx_data toggling randomly for 20 cycles -> no output, pointer or memory change.
